// File: rtl/k580vt57_dma.sv
// Four-channel DMA controller (K580VT57 / i8257 subset): CPU register file, hold handshake,
// channel arbitration, S1-S3 transfer sequencing, terminal count and ch3->ch2 autoload.
module k580vt57_dma (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  iaddr,
    input  logic [7:0]  idata,
    output logic [7:0]  odata,
    input  logic        iwe_n,
    input  logic        ird_n,
    input  logic [3:0]  drq,
    input  logic        hlda,
    output logic        hrq,
    output logic [3:0]  dack,
    output logic [15:0] oaddr,
    output logic        memr,
    output logic        memw,
    output logic        iord,
    output logic        iowr,
    output logic        tc
);

    typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_S1, ST_S2, ST_S3} state_t;

    state_t      state_reg;
    logic [15:0] addr_reg [4];
    logic [15:0] cnt_reg  [4];
    logic [7:0]  mode_reg;
    logic [3:0]  tcf_reg;
    logic        upd_reg;
    logic        ff_reg;
    logic [1:0]  ch_reg;
    logic [1:0]  last_reg;
    logic        iwe_q_reg;
    logic        ird_q_reg;

    logic        wr_pulse;
    logic        rd_pulse;
    logic [3:0]  req;
    logic [3:0]  req_s3;
    logic [3:0]  en_after;
    logic        last_byte;
    logic        autoload_hit;
    logic [1:0]  win_wait;
    logic [1:0]  win_s3;
    logic [15:0] s3_addr_next;
    logic [15:0] s3_oaddr_next;
    logic [15:0] rd_sel;

    // First requesting channel at or after 'start', wrapping 3 -> 0.
    function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] start);
        logic [1:0] res;
        logic [1:0] idx;
        logic       found;
        res   = start;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = start + 2'(k);
            if (!found && r[idx]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    assign wr_pulse = iwe_n & ~iwe_q_reg;
    assign rd_pulse = ird_n & ~ird_q_reg;
    assign req      = drq & mode_reg[3:0];

    always_comb begin
        last_byte    = (cnt_reg[ch_reg][13:0] == 14'd0);
        autoload_hit = last_byte && (ch_reg == 2'd2) && mode_reg[7];
        en_after     = mode_reg[3:0];
        // Autoload keeps channel 2 running even when TC-stop is also selected.
        if (last_byte && mode_reg[6] && !autoload_hit)
            en_after[ch_reg] = 1'b0;
        req_s3        = drq & en_after;
        win_wait      = pick(req, mode_reg[4] ? last_reg + 2'd1 : 2'd0);
        win_s3        = pick(req_s3, mode_reg[4] ? ch_reg + 2'd1 : 2'd0);
        s3_addr_next  = autoload_hit ? addr_reg[3] : addr_reg[ch_reg] + 16'd1;
        s3_oaddr_next = (win_s3 == ch_reg) ? s3_addr_next : addr_reg[win_s3];
    end

    always_comb begin
        odata  = 8'h00;
        rd_sel = iaddr[0] ? cnt_reg[iaddr[2:1]] : addr_reg[iaddr[2:1]];
        if (!iaddr[3])
            odata = ff_reg ? rd_sel[15:8] : rd_sel[7:0];
        else if (iaddr == 4'd8)
            odata = {3'b000, upd_reg, tcf_reg};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
            for (int i = 0; i < 4; i++) begin
                addr_reg[i] <= 16'h0000;
                cnt_reg[i]  <= 16'h0000;
            end
            mode_reg  <= 8'h00;
            tcf_reg   <= 4'h0;
            upd_reg   <= 1'b0;
            ff_reg    <= 1'b0;
            ch_reg    <= 2'd0;
            last_reg  <= 2'd3;
            iwe_q_reg <= 1'b1;
            ird_q_reg <= 1'b1;
            hrq       <= 1'b0;
            dack      <= 4'h0;
            oaddr     <= 16'h0000;
            memr      <= 1'b0;
            memw      <= 1'b0;
            iord      <= 1'b0;
            iowr      <= 1'b0;
            tc        <= 1'b0;
        end else begin
            iwe_q_reg <= iwe_n;
            ird_q_reg <= ird_n;

            // Status read clears flags first, so a flag raised in the same clk survives.
            if (rd_pulse) begin
                if (!iaddr[3]) begin
                    ff_reg <= ~ff_reg;
                end else if (iaddr == 4'd8) begin
                    ff_reg  <= 1'b0;
                    tcf_reg <= 4'h0;
                    upd_reg <= 1'b0;
                end
            end

            case (state_reg)
                ST_IDLE: begin
                    if (|req) begin
                        hrq       <= 1'b1;
                        state_reg <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!(|req)) begin
                        hrq       <= 1'b0;
                        state_reg <= ST_IDLE;
                    end else if (hlda) begin
                        ch_reg    <= win_wait;
                        oaddr     <= addr_reg[win_wait];
                        dack      <= 4'b0001 << win_wait;
                        state_reg <= ST_S1;
                    end
                end
                ST_S1: begin
                    tc <= last_byte;
                    case (cnt_reg[ch_reg][15:14])
                        2'b10: begin
                            memr <= 1'b1;
                            iowr <= 1'b1;
                        end
                        2'b01: begin
                            memw <= 1'b1;
                            iord <= 1'b1;
                        end
                        default: ;
                    endcase
                    state_reg <= ST_S2;
                end
                ST_S2: begin
                    memr      <= 1'b0;
                    memw      <= 1'b0;
                    iord      <= 1'b0;
                    iowr      <= 1'b0;
                    tc        <= 1'b0;
                    dack      <= 4'h0;
                    state_reg <= ST_S3;
                end
                ST_S3: begin
                    addr_reg[ch_reg]       <= addr_reg[ch_reg] + 16'd1;
                    cnt_reg[ch_reg][13:0]  <= cnt_reg[ch_reg][13:0] - 14'd1;
                    last_reg               <= ch_reg;
                    if (last_byte) begin
                        tcf_reg[ch_reg] <= 1'b1;
                        mode_reg[3:0]   <= en_after;
                        if (autoload_hit) begin
                            addr_reg[2] <= addr_reg[3];
                            cnt_reg[2]  <= cnt_reg[3];
                            upd_reg     <= 1'b1;
                        end
                    end
                    if ((|req_s3) && hlda) begin
                        ch_reg    <= win_s3;
                        oaddr     <= s3_oaddr_next;
                        dack      <= 4'b0001 << win_s3;
                        state_reg <= ST_S1;
                    end else begin
                        hrq       <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase

            // CPU writes come last so they override a same-clk S3 update of that register.
            if (wr_pulse) begin
                if (!iaddr[3]) begin
                    ff_reg <= ~ff_reg;
                    if (iaddr[0]) begin
                        if (ff_reg) cnt_reg[iaddr[2:1]][15:8] <= idata;
                        else        cnt_reg[iaddr[2:1]][7:0]  <= idata;
                    end else begin
                        if (ff_reg) addr_reg[iaddr[2:1]][15:8] <= idata;
                        else        addr_reg[iaddr[2:1]][7:0]  <= idata;
                    end
                end else if (iaddr == 4'd8) begin
                    mode_reg <= idata;
                    ff_reg   <= 1'b0;
                end
            end
        end
    end

endmodule
